// File: rtl/t07_wb_pkg.sv
// Shared types and constants for the writeback select stage.
package t07_wb_pkg;

   typedef enum logic [2:0] {
      WB_PC  = 3'd0,
      WB_MEM = 3'd1,
      WB_ALU = 3'd2,
      WB_FPU = 3'd3,
      WB_IMM = 3'd4
   } wb_sel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2
   } wb_state_t;

   localparam logic [31:0] WB_ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/t07_wb_select_stage_timeout.sv
// Wait-cycle counter: o_expire flags the last allowed WAIT cycle; tied off when TIMEOUT is 0.
module t07_wb_timeout_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic nRst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign o_expire = 1'b0;
      end else begin : g_on
         localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
         logic [CNT_W-1:0] r_cnt;

         always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
               r_cnt <= '0;
            end else if (i_clr) begin
               r_cnt <= '0;
            end else if (i_en) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end

         assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/t07_wb_select_stage.sv
// Writeback select stage: accepts one request, waits on the selected source, issues a one-cycle RF write.
module t07_wb_select_stage
   import t07_wb_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                N_SRC    = 5,
   parameter int                SEL_W    = 3,
   parameter int                TIMEOUT  = 64,
   parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(WB_ERR_WORD)
) (
   input  logic                    clk,
   input  logic                    nRst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [SEL_W-1:0]        req_sel,
   input  logic [4:0]              req_rd,
   input  logic                    req_we,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   input  logic [N_SRC-1:0]        src_valid,
   output logic [N_SRC-1:0]        src_ack,
   output logic                    rf_we,
   output logic [4:0]              rf_rd,
   output logic [DATA_W-1:0]       rf_wdata,
   output logic                    busy,
   output logic                    err_illegal_sel,
   output logic                    err_timeout
);

   wb_state_t         r_state, w_state_nxt;
   logic              r_ready_en;
   logic [SEL_W-1:0]  r_sel_q;
   logic [4:0]        r_rd_q;
   logic              r_we_q;
   logic              r_rf_we, r_err_ill, r_err_to;
   logic [4:0]        r_rf_rd;
   logic [DATA_W-1:0] r_rf_wdata;

   logic              w_accept, w_sel_ok, w_src_vld, w_fire, w_expire;
   logic              w_cnt_clr, w_cnt_en, w_to_write, w_wr_we, w_ill, w_tmo;
   logic [4:0]        w_wr_rd;
   logic [DATA_W-1:0] w_src_data, w_wr_data;

   // req_ready stays low until the first clock after reset release.
   assign req_ready = r_ready_en && ((r_state == IDLE) || (r_state == WRITE));
   assign w_accept  = req_valid && req_ready;
   assign w_sel_ok  = ({1'b0, req_sel} < (SEL_W+1)'(N_SRC));
   assign busy      = (r_state != IDLE);

   always_comb begin
      w_src_data = '0;
      w_src_vld  = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (r_sel_q == SEL_W'(i)) begin
            w_src_data = src_data[i*DATA_W +: DATA_W];
            w_src_vld  = src_valid[i];
         end
      end
   end

   assign src_ack = w_fire ? (N_SRC'(1) << r_sel_q) : '0;

   t07_wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .nRst     (nRst),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;
      w_to_write  = 1'b0;
      w_wr_rd     = r_rd_q;
      w_wr_we     = r_we_q;
      w_wr_data   = w_src_data;
      w_ill       = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         IDLE, WRITE: begin
            w_state_nxt = IDLE;
            if (w_accept) begin
               if (w_sel_ok) begin
                  w_state_nxt = WAIT;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_state_nxt = WRITE;
                  w_to_write  = 1'b1;
                  w_wr_rd     = req_rd;
                  w_wr_we     = req_we;
                  w_wr_data   = ERR_WORD;
                  w_ill       = 1'b1;
               end
            end
         end
         WAIT: begin
            if (w_src_vld) begin
               w_fire      = 1'b1;
               w_state_nxt = WRITE;
               w_to_write  = 1'b1;
            end else begin
               w_cnt_en = 1'b1;
               if (w_expire) begin
                  w_state_nxt = WRITE;
                  w_to_write  = 1'b1;
                  w_wr_data   = ERR_WORD;
                  w_tmo       = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state    <= IDLE;
         r_ready_en <= 1'b0;
         r_sel_q    <= '0;
         r_rd_q     <= '0;
         r_we_q     <= 1'b0;
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_wdata <= '0;
         r_err_ill  <= 1'b0;
         r_err_to   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ready_en <= 1'b1;
         if (w_accept) begin
            r_sel_q <= req_sel;
            r_rd_q  <= req_rd;
            r_we_q  <= req_we;
         end
         // Write strobe and error pulses are registered so they line up with the WRITE cycle.
         r_rf_we   <= w_to_write && w_wr_we && (w_wr_rd != 5'd0);
         r_err_ill <= w_ill;
         r_err_to  <= w_tmo;
         if (w_to_write) begin
            r_rf_rd    <= w_wr_rd;
            r_rf_wdata <= w_wr_data;
         end
      end
   end

   assign rf_we           = r_rf_we;
   assign rf_rd           = r_rf_rd;
   assign rf_wdata        = r_rf_wdata;
   assign err_illegal_sel = r_err_ill;
   assign err_timeout     = r_err_to;

endmodule

// File: tb/tb_t07_wb_select_stage.sv
// Directed bench for t07_wb_select_stage with a write scoreboard (TIMEOUT=4).
module tb_t07_wb_select_stage;
   import t07_wb_pkg::*;

   localparam int DW = 32;
   localparam int NS = 5;
   localparam int SW = 3;
   localparam int TO = 4;

   logic             clk = 1'b0;
   logic             nRst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [SW-1:0]    req_sel = '0;
   logic [4:0]       req_rd = '0;
   logic             req_we = 1'b0;
   logic [NS*DW-1:0] src_data = '0;
   logic [NS-1:0]    src_valid = '0;
   logic [NS-1:0]    src_ack;
   logic             rf_we;
   logic [4:0]       rf_rd;
   logic [DW-1:0]    rf_wdata;
   logic             busy;
   logic             err_illegal_sel;
   logic             err_timeout;

   int   checks = 0;
   int   failures = 0;
   logic mon_en = 1'b0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        ill;
      logic        tmo;
   } exp_t;
   exp_t sb_q[$];

   t07_wb_select_stage #(
      .DATA_W(DW), .N_SRC(NS), .SEL_W(SW), .TIMEOUT(TO), .ERR_WORD(32'hDEADBEEF)
   ) dut (
      .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_ready(req_ready),
      .req_sel(req_sel), .req_rd(req_rd), .req_we(req_we),
      .src_data(src_data), .src_valid(src_valid), .src_ack(src_ack),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy),
      .err_illegal_sel(err_illegal_sel), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [31:0] d);
      src_data[i*DW +: DW] = d;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic we,
                       input logic ill, input logic tmo);
      exp_t e;
      e.rd = rd; e.data = d; e.we = we && (rd != 5'd0); e.ill = ill; e.tmo = tmo;
      sb_q.push_back(e);
   endtask

   always begin : monitor
      exp_t e;
      @(posedge clk);
      #1;
      if (mon_en && (rf_we || err_illegal_sel || err_timeout)) begin
         chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_rf_we", 32'(rf_we), 32'(e.we));
            chk("sb_rf_rd", 32'(rf_rd), 32'(e.rd));
            chk("sb_rf_wdata", rf_wdata, e.data);
            chk("sb_err_ill", 32'(err_illegal_sel), 32'(e.ill));
            chk("sb_err_to", 32'(err_timeout), 32'(e.tmo));
         end
      end
   end

   initial begin
      // Reset state
      #2;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rf_rd", 32'(rf_rd), 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_src_ack", 32'(src_ack), 0);
      chk("rst_err", 32'({err_illegal_sel, err_timeout}), 0);
      tick(); tick();
      nRst = 1'b1;
      mon_en = 1'b1;
      tick();
      chk("ready_after_reset", 32'(req_ready), 1);

      // 1. ALU already valid
      set_src(2, 32'h0000_1234);
      src_valid = 5'b00100;
      req_sel = WB_ALU; req_rd = 5'd5; req_we = 1'b1; req_valid = 1'b1;
      push(5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
      tick();
      req_valid = 1'b0;
      chk("t1_ack", 32'(src_ack), 32'b00100);
      chk("t1_no_we_yet", 32'(rf_we), 0);
      chk("t1_busy", 32'(busy), 1);
      tick();
      chk("t1_rf_we", 32'(rf_we), 1);
      chk("t1_rf_wdata", rf_wdata, 32'h0000_1234);
      chk("t1_ack_done", 32'(src_ack), 0);
      src_valid = '0;
      tick();
      chk("t1_idle_we", 32'(rf_we), 0);
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_hold_rd", 32'(rf_rd), 5);

      // 2. Memory late
      set_src(1, 32'hCAFE_0001);
      req_sel = WB_MEM; req_rd = 5'd7; req_we = 1'b1; req_valid = 1'b1;
      push(5'd7, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
      tick();
      req_valid = 1'b0;
      chk("t2_busy_t1", 32'(busy), 1);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("t2_busy_wait", 32'(busy), 1);
         chk("t2_no_ack", 32'(src_ack), 0);
      end
      tick();
      src_valid = 5'b00010;
      #1;
      chk("t2_busy_t4", 32'(busy), 1);
      chk("t2_ack", 32'(src_ack), 32'b00010);
      tick();
      chk("t2_rf_we", 32'(rf_we), 1);
      chk("t2_rf_wdata", rf_wdata, 32'hCAFE_0001);
      src_valid = '0;
      tick();

      // 3. Illegal select
      src_valid = 5'b11111;
      req_sel = 3'b110; req_rd = 5'd3; req_we = 1'b1; req_valid = 1'b1;
      push(5'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      tick();
      req_valid = 1'b0;
      chk("t3_rf_we", 32'(rf_we), 1);
      chk("t3_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk("t3_err_ill", 32'(err_illegal_sel), 1);
      chk("t3_no_ack", 32'(src_ack), 0);
      tick();
      chk("t3_err_ill_end", 32'(err_illegal_sel), 0);
      src_valid = '0;

      // 4. Timeout on FPU, other sources valid but ignored
      src_valid = 5'b00101;
      req_sel = WB_FPU; req_rd = 5'd9; req_we = 1'b1; req_valid = 1'b1;
      push(5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
      tick();
      req_valid = 1'b0;
      for (int w = 0; w < TO; w++) begin
         chk("t4_no_to_yet", 32'(err_timeout), 0);
         chk("t4_no_ack", 32'(src_ack), 0);
         chk("t4_no_we", 32'(rf_we), 0);
         tick();
      end
      chk("t4_err_to", 32'(err_timeout), 1);
      chk("t4_rf_we", 32'(rf_we), 1);
      chk("t4_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      src_valid = '0;
      tick();
      chk("t4_err_to_end", 32'(err_timeout), 0);

      // 5. Back-to-back, then an x0 request
      set_src(4, 32'h0000_4444);
      set_src(0, 32'h0000_0100);
      src_valid = 5'b10001;
      req_sel = WB_IMM; req_rd = 5'd1; req_we = 1'b1; req_valid = 1'b1;
      push(5'd1, 32'h0000_4444, 1'b1, 1'b0, 1'b0);
      push(5'd2, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
      tick();
      chk("t5_ack_a", 32'(src_ack), 32'b10000);
      req_sel = WB_PC; req_rd = 5'd2;
      tick();
      chk("t5_we_a", 32'(rf_we), 1);
      chk("t5_ready_in_write", 32'(req_ready), 1);
      tick();
      chk("t5_gap", 32'(rf_we), 0);
      chk("t5_ack_b", 32'(src_ack), 32'b00001);
      set_src(2, 32'h0000_0055);
      src_valid = 5'b10101;
      req_sel = WB_ALU; req_rd = 5'd0;
      tick();
      chk("t5_we_b", 32'(rf_we), 1);
      chk("t5_rd_b", 32'(rf_rd), 2);
      tick();
      req_valid = 1'b0;
      chk("t5_ack_x0", 32'(src_ack), 32'b00100);
      tick();
      chk("t5_x0_no_we", 32'(rf_we), 0);
      chk("t5_x0_busy", 32'(busy), 1);
      chk("t5_x0_rd", 32'(rf_rd), 0);
      src_valid = '0;
      tick();

      // 6. Reset while waiting
      set_src(1, 32'h1111_2222);
      req_sel = WB_MEM; req_rd = 5'd11; req_we = 1'b1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("t6_busy", 32'(busy), 1);
      #2;
      nRst = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_ready", 32'(req_ready), 0);
      chk("t6_rst_rf_rd", 32'(rf_rd), 0);
      chk("t6_rst_rf_wdata", rf_wdata, 0);
      src_valid = 5'b00010;
      #1;
      chk("t6_rst_ack", 32'(src_ack), 0);
      tick(); tick();
      nRst = 1'b1;
      tick();
      chk("t6_ready_after", 32'(req_ready), 1);
      chk("t6_no_ack", 32'(src_ack), 0);
      tick();
      chk("t6_no_ack2", 32'(src_ack), 0);
      chk("t6_no_we", 32'(rf_we), 0);
      src_valid = '0;
      tick();

      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
